// File: rtl/cpu_core_pkg.sv
// Shared definitions for cpu_core: FSM states, opcode values and instruction field layout.
package cpu_core_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_OR    = 6'd4;
  localparam logic [5:0] OP_XOR   = 6'd5;
  localparam logic [5:0] OP_LDI   = 6'd6;
  localparam logic [5:0] OP_STORE = 6'd7;
  localparam logic [5:0] OP_LOAD  = 6'd8;
  localparam logic [5:0] OP_JMP   = 6'd9;
  localparam logic [5:0] OP_JZ    = 6'd10;
  localparam logic [5:0] OP_HALT  = 6'd11;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_LSB  = 9;
  localparam int unsigned RD_LSB  = 12;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned HL_BIT  = 15;
  localparam int unsigned IMM_LSB = 16;
  localparam int unsigned IMM_W   = 16;

  function automatic logic [OP_W-1:0] insn_op(input logic [31:0] insn);
    return insn[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_W-1:0] insn_reg(input logic [31:0] insn, input int unsigned lsb);
    return insn[lsb +: REG_W];
  endfunction

  function automatic logic [IMM_W-1:0] insn_imm(input logic [31:0] insn);
    return insn[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Eight-entry register file with per-register zero flags, two async read ports, one sync write port.
module cpu_regfile #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_zero,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [8];
  logic [7:0]        flags;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
      flags <= '0;
    end else if (wr_en) begin
      regs[wr_addr]  <= wr_data;
      flags[wr_addr] <= (wr_data == '0);
    end
  end

  assign ra_data = regs[ra_addr];
  assign ra_zero = flags[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle FETCH/EXEC/MEM/HALT core with a single-port word-addressed memory interface.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       insn;

  logic [5:0]        op;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [2:0]        rd;
  logic              hl;
  logic [15:0]       imm;

  logic [2:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_zero;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] alu_res;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;

  assign op  = insn_op(insn);
  assign ra  = insn_reg(insn, RA_LSB);
  assign rb  = insn_reg(insn, RB_LSB);
  assign rd  = insn_reg(insn, RD_LSB);
  assign hl  = insn[HL_BIT];
  assign imm = insn_imm(insn);

  // LDI with hl=1 merges into the old rd value, so port A reads rd instead of ra.
  assign a_addr = (op == OP_LDI) ? rd : ra;

  cpu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (a_addr),
    .ra_data (a_data),
    .ra_zero (a_zero),
    .rb_addr (rb),
    .rb_data (b_data),
    .wr_en   (wb_en),
    .wr_addr (rd),
    .wr_data (wb_data)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = a_data + b_data;
      OP_SUB: alu_res = a_data - b_data;
      OP_AND: alu_res = a_data & b_data;
      OP_OR:  alu_res = a_data | b_data;
      OP_XOR: alu_res = a_data ^ b_data;
      OP_LDI: begin
        if (hl) begin
          alu_res        = a_data;
          alu_res[31:16] = imm;
        end else begin
          alu_res[15:0]  = imm;
        end
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_res;
    if (state == ST_EXEC && (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI})) begin
      wb_en = 1'b1;
    end else if (state == ST_MEM && op == OP_LOAD && mem_ready) begin
      wb_en   = 1'b1;
      wb_data = mem_rdata;
    end
  end

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    next_pc = pc_inc;
    if (op == OP_JMP)
      next_pc = a_data[ADDR_W-1:0];
    else if (op == OP_JZ && a_zero)
      next_pc = b_data[ADDR_W-1:0];
  end

  // Bus outputs are loaded on the edge that enters each state, so they hold steady through wait cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      insn      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            insn    <= mem_rdata[31:0];
            mem_req <= 1'b0;
            illegal <= (mem_rdata[OP_LSB +: OP_W] > OP_HALT);
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_STORE, OP_LOAD: begin
              state     <= ST_MEM;
              mem_req   <= 1'b1;
              mem_we    <= (op == OP_STORE);
              mem_addr  <= a_data[ADDR_W-1:0];
              mem_wdata <= b_data;
              pc        <= pc_inc;
            end
            OP_HALT: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            default: begin
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= next_pc;
              pc       <= next_pc;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        ST_HALT: begin
          mem_req <= 1'b0;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expected bus accesses are queued, a negedge monitor pops and compares.
module tb_cpu_core;
  import cpu_core_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req, mem_we, halted, illegal;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;

  always #5 clock = ~clock;

  cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } acc_t;

  acc_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ill_cnt  = 0;
  int          ready_mode = 0;
  int          wait_cnt = 0;
  logic        load_req = 1'b0;
  logic [31:0] prog [256];
  logic [31:0] mem  [256];

  // Memory model: program image copied in on request, DUT stores applied on completion.
  always_comb mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else if (reset && mem_req && mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // mode 0: always ready; mode 1: three wait cycles per write; mode 2: writes never complete.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1 && mem_req && mem_we && wait_cnt < 3) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else if (ready_mode == 2 && mem_req && mem_we) begin
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
        if (!(mem_req && mem_we)) wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (illegal) ill_cnt++;
        if (mem_req && mem_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_access_addr", 64'(mem_addr), 64'hFFFF);
          end else begin
            acc_t e;
            e = sb.pop_front();
            check("acc_we", 64'(mem_we), 64'(e.we));
            check("acc_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) check("acc_wdata", 64'(mem_wdata), 64'(e.wdata));
          end
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [2:0] rd, input logic hl, input logic [15:0] imm);
    return {imm, hl, rd, rb, ra, op};
  endfunction

  task automatic exp_fetch(input logic [AW-1:0] a);
    acc_t e;
    e.we = 1'b0; e.addr = a; e.wdata = '0;
    sb.push_back(e);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
    acc_t e;
    e.we = 1'b1; e.addr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    acc_t e;
    e.we = 1'b0; e.addr = a; e.wdata = '0;
    sb.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  // Holds reset, loads the image, checks reset values, releases, and checks the first fetch.
  task automatic start();
    reset = 1'b0;
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("rst_reg", 64'(dut.u_rf.regs[i]), 64'd0);
      check("rst_flag", 64'(dut.u_rf.flags[i]), 64'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("first_fetch_req", 64'(mem_req), 64'd1);
    check("first_fetch_addr", 64'(mem_addr), 64'h00);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("halt_reached", 64'(halted), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_write(input int budget);
    int n = 0;
    @(negedge clock);
    while (!(mem_req && mem_we) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("write_seen", 64'(mem_req && mem_we), 64'd1);
  endtask

  initial begin
    int ill0;

    // LDI/LDI/SUB/HALT: halted exactly after eight cycles from the first fetch.
    clear_prog();
    prog[0] = enc(OP_LDI, 3'd0, 3'd0, 3'd1, 1'b0, 16'd5);
    prog[1] = enc(OP_LDI, 3'd0, 3'd0, 3'd2, 1'b0, 16'd5);
    prog[2] = enc(OP_SUB, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0);
    prog[3] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0);
    sb.delete();
    for (int a = 0; a < 4; a++) exp_fetch(AW'(a));
    start();
    repeat (7) @(posedge clock);
    #1;
    check("halted_early", 64'(halted), 64'd0);
    @(posedge clock);
    #1;
    check("halted_at_8", 64'(halted), 64'd1);
    check("sub_r3", 64'(dut.u_rf.regs[3]), 64'd0);
    check("sub_flag3", 64'(dut.u_rf.flags[3]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("halt_no_req", 64'(mem_req), 64'd0);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    // ALU wrap, LDI high half, read-before-write, stores and a load.
    clear_prog();
    prog[0]  = enc(OP_LDI,   3'd0, 3'd0, 3'd1, 1'b0, 16'hFFFF);
    prog[1]  = enc(OP_LDI,   3'd0, 3'd0, 3'd1, 1'b1, 16'hFFFF);
    prog[2]  = enc(OP_LDI,   3'd0, 3'd0, 3'd2, 1'b0, 16'h0001);
    prog[3]  = enc(OP_ADD,   3'd1, 3'd2, 3'd4, 1'b0, 16'h0);
    prog[4]  = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0020);
    prog[5]  = enc(OP_STORE, 3'd5, 3'd4, 3'd0, 1'b0, 16'h0);
    prog[6]  = enc(OP_LDI,   3'd0, 3'd0, 3'd6, 1'b0, 16'h1234);
    prog[7]  = enc(OP_LDI,   3'd0, 3'd0, 3'd6, 1'b1, 16'hABCD);
    prog[8]  = enc(OP_XOR,   3'd6, 3'd1, 3'd7, 1'b0, 16'h0);
    prog[9]  = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0021);
    prog[10] = enc(OP_STORE, 3'd5, 3'd7, 3'd0, 1'b0, 16'h0);
    prog[11] = enc(OP_SUB,   3'd1, 3'd2, 3'd1, 1'b0, 16'h0);
    prog[12] = enc(OP_LOAD,  3'd5, 3'd0, 3'd3, 1'b0, 16'h0);
    prog[13] = enc(OP_OR,    3'd3, 3'd4, 3'd3, 1'b0, 16'h0);
    prog[14] = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0022);
    prog[15] = enc(OP_STORE, 3'd5, 3'd1, 3'd0, 1'b0, 16'h0);
    prog[16] = enc(OP_AND,   3'd6, 3'd1, 3'd0, 1'b0, 16'h0);
    prog[17] = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0023);
    prog[18] = enc(OP_STORE, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0);
    prog[19] = enc(OP_HALT,  3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    sb.delete();
    for (int a = 0; a <= 5; a++) exp_fetch(AW'(a));
    exp_wr(8'h20, 32'h0000_0000);
    for (int a = 6; a <= 10; a++) exp_fetch(AW'(a));
    exp_wr(8'h21, 32'h5432_EDCB);
    exp_fetch(8'd11);
    exp_fetch(8'd12);
    exp_rd(8'h21);
    for (int a = 13; a <= 15; a++) exp_fetch(AW'(a));
    exp_wr(8'h22, 32'hFFFF_FFFE);
    for (int a = 16; a <= 18; a++) exp_fetch(AW'(a));
    exp_wr(8'h23, 32'hABCD_1234);
    exp_fetch(8'd19);
    start();
    wait_halt(200);
    check("add_wrap_r4", 64'(dut.u_rf.regs[4]), 64'd0);
    check("add_wrap_flag4", 64'(dut.u_rf.flags[4]), 64'd1);
    check("load_r3", 64'(dut.u_rf.regs[3]), 64'h5432_EDCB);
    check("load_flag3", 64'(dut.u_rf.flags[3]), 64'd0);
    check("sub_self_r1", 64'(dut.u_rf.regs[1]), 64'hFFFF_FFFE);
    check("and_flag0", 64'(dut.u_rf.flags[0]), 64'd0);

    // Store with three wait cycles: bus held for four cycles, then fetch pc+1.
    clear_prog();
    prog[0] = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0010);
    prog[1] = enc(OP_LDI,   3'd0, 3'd0, 3'd6, 1'b0, 16'hBEEF);
    prog[2] = enc(OP_LDI,   3'd0, 3'd0, 3'd6, 1'b1, 16'hDEAD);
    prog[3] = enc(OP_STORE, 3'd5, 3'd6, 3'd0, 1'b0, 16'h0);
    prog[4] = enc(OP_NOP,   3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    prog[5] = enc(OP_HALT,  3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    sb.delete();
    for (int a = 0; a <= 3; a++) exp_fetch(AW'(a));
    exp_wr(8'h10, 32'hDEAD_BEEF);
    exp_fetch(8'd4);
    exp_fetch(8'd5);
    ready_mode = 1;
    start();
    wait_write(50);
    for (int k = 0; k < 4; k++) begin
      check("stall_req", 64'(mem_req), 64'd1);
      check("stall_we", 64'(mem_we), 64'd1);
      check("stall_addr", 64'(mem_addr), 64'h10);
      check("stall_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("stall_ready", 64'(mem_ready), (k == 3) ? 64'd1 : 64'd0);
      @(negedge clock);
    end
    check("post_store_we", 64'(mem_we), 64'd0);
    check("post_store_addr", 64'(mem_addr), 64'h04);
    wait_halt(50);
    check("store_mem", 64'(mem[8'h10]), 64'hDEAD_BEEF);
    ready_mode = 0;

    // Reset while a write is stalled in MEM.
    clear_prog();
    prog[0] = enc(OP_LDI,   3'd0, 3'd0, 3'd5, 1'b0, 16'h0030);
    prog[1] = enc(OP_LDI,   3'd0, 3'd0, 3'd1, 1'b0, 16'h0007);
    prog[2] = enc(OP_STORE, 3'd5, 3'd1, 3'd0, 1'b0, 16'h0);
    sb.delete();
    for (int a = 0; a <= 2; a++) exp_fetch(AW'(a));
    ready_mode = 2;
    start();
    wait_write(50);
    @(negedge clock);
    @(negedge clock);
    check("mem_wait_held", 64'(mem_ready), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req", 64'(mem_req), 64'd0);
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_r1", 64'(dut.u_rf.regs[1]), 64'd0);
    check("midrst_r5", 64'(dut.u_rf.regs[5]), 64'd0);
    check("midrst_no_write", 64'(mem[8'h30]), 64'd0);
    ready_mode = 0;
    prog[0] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    sb.delete();
    exp_fetch(8'h00);
    start();
    wait_halt(20);

    // pc wrap at 0xFF, JZ taken/not taken, illegal opcode pulse.
    clear_prog();
    prog[0]     = enc(OP_JZ,   3'd6, 3'd2, 3'd0, 1'b0, 16'h0);
    prog[1]     = enc(OP_LDI,  3'd0, 3'd0, 3'd1, 1'b0, 16'h00FF);
    prog[2]     = enc(OP_LDI,  3'd0, 3'd0, 3'd6, 1'b0, 16'h0000);
    prog[3]     = enc(OP_LDI,  3'd0, 3'd0, 3'd2, 1'b0, 16'h0060);
    prog[4]     = enc(OP_JMP,  3'd1, 3'd0, 3'd0, 1'b0, 16'h0);
    prog[8'hFF] = enc(OP_NOP,  3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    prog[8'h60] = enc(6'h3F,   3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    prog[8'h61] = enc(OP_LDI,  3'd0, 3'd0, 3'd5, 1'b0, 16'h0003);
    prog[8'h62] = enc(OP_LDI,  3'd0, 3'd0, 3'd6, 1'b0, 16'h0070);
    prog[8'h63] = enc(OP_JZ,   3'd5, 3'd6, 3'd0, 1'b0, 16'h0);
    prog[8'h64] = enc(OP_LDI,  3'd0, 3'd0, 3'd5, 1'b0, 16'h0000);
    prog[8'h65] = enc(OP_JZ,   3'd5, 3'd6, 3'd0, 1'b0, 16'h0);
    prog[8'h70] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    sb.delete();
    for (int a = 0; a <= 4; a++) exp_fetch(AW'(a));
    exp_fetch(8'hFF);
    exp_fetch(8'h00);
    for (int a = 8'h60; a <= 8'h65; a++) exp_fetch(AW'(a));
    exp_fetch(8'h70);
    ill0 = ill_cnt;
    start();
    wait_halt(200);
    check("illegal_pulse_cycles", 64'(ill_cnt - ill0), 64'd1);
    check("illegal_low_after", 64'(illegal), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DATA_W, default 32, meaning register/data width; legal values 32..64.
REQ-002 Parameter ADDR_W, default 32, meaning memory word-address width; legal values 8..32.
REQ-003 Parameter RESET_PC, default 0, meaning the fetch address after reset, ADDR_W bits.
REQ-004 Port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, meaning reset, asynchronous, active-low.
REQ-006 Port mem_req, output, 1, meaning memory request valid.
REQ-007 Port mem_we, output, 1, meaning 1 = write, 0 = read; valid while mem_req is 1.
REQ-008 Port mem_addr, output, ADDR_W, meaning word address.
REQ-009 Port mem_wdata, output, DATA_W, meaning store data.
REQ-010 Port mem_rdata, input, DATA_W, meaning read data; valid when mem_ready is 1.
REQ-011 Port mem_ready, input, 1, meaning the access completes this cycle.
REQ-012 Port halted, output, 1, meaning the core is in HALT.
REQ-013 Port illegal, output, 1, meaning a one-cycle pulse on an undefined opcode.

Function
REQ-014 Instruction fields SHALL be: op[5:0], ra[8:6], rb[11:9], rd[14:12], hl[15], imm[31:16], taken from mem_rdata[31:0].
REQ-015 The core SHALL contain eight DATA_W registers r0..r7 and one zero flag per register; r0 is an ordinary register.
REQ-016 The FSM SHALL have four states: FETCH, EXEC, MEM and HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, latch the instruction and go to EXEC.
  - EXEC: one cycle.
  - MEM: access as in REQ-021; on mem_ready, go to FETCH.
  - HALT: absorbing.
REQ-017 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable while mem_req=1 and mem_ready=0; there is no timeout.
REQ-018 Opcodes executed in EXEC SHALL be:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = ra op rb, modulo 2^DATA_W.
  - 6 LDI.
  - 7 STORE, 8 LOAD.
  - 9 JMP: pc = ra[ADDR_W-1:0].
  - 10 JZ: if flag[ra]=1 then pc = rb[ADDR_W-1:0].
  - 11 HALT.
REQ-019 LDI SHALL behave as follows:
  - hl=0: rd = zero-extended imm.
  - hl=1: rd[31:16] = imm, all other bits unchanged.
REQ-020 ADD/SUB/AND/OR/XOR, LDI and LOAD SHALL set flag[rd] = (result == 0); all other opcodes leave flags unchanged.
REQ-021 STORE and LOAD SHALL go EXEC to MEM with mem_addr = ra[ADDR_W-1:0].
  - STORE: mem_we=1, mem_wdata = rb.
  - LOAD: mem_we=0; on mem_ready, rd = mem_rdata and flag[rd] updates.
REQ-022 pc SHALL increment by 1 in EXEC unless a jump is taken; increment from 2^ADDR_W-1 wraps to 0.
REQ-023 Source operands SHALL be read before writeback, so rd == ra or rd == rb uses the old value.
REQ-024 Opcodes 12..63 SHALL execute as NOP, pulse illegal for exactly the EXEC cycle, and increment pc.
REQ-025 HALT SHALL set halted=1 and mem_req=0 with pc frozen; the core leaves HALT only by reset.
REQ-026 Latency with mem_ready tied high:
  - ALU, LDI, NOP, JMP, JZ and illegal: 2 cycles.
  - LOAD and STORE: 3 cycles.
  - Each wait cycle adds 1.
REQ-027 All outputs SHALL be decoded from registered state only, with no combinational path from mem_rdata or mem_ready to any output.

Reset
REQ-028 While reset=0, outputs SHALL be as follows, independent of clock:
  - pc = RESET_PC.
  - All registers and flags 0.
  - state = FETCH.
  - mem_req = 0, mem_we = 0.
  - illegal = 0, halted = 0.
REQ-029 Reset asserted mid-access SHALL drop mem_req immediately and discard the access; no register writes.
REQ-030 After reset deasserts, the first rising edge SHALL begin FETCH at RESET_PC, with mem_req=1 from that cycle.

Structure
REQ-031 Package cpu_core_pkg SHALL hold:
  - the opcode constants;
  - the FSM state encoding;
  - the instruction field bit positions.
REQ-032 Sub-module cpu_regfile SHALL implement the 8xDATA_W registers plus zero flags.
  - Two asynchronous read ports.
  - One synchronous write port.
  - Asynchronous active-low clear.

Verification
REQ-033 With mem_ready=1 and program LDI r1,5; LDI r2,5; SUB r3,r1,r2; HALT, the bench SHALL check: r3=0, flag[r3]=1, halted=1 after 8 cycles, mem_req=0 afterwards.
REQ-034 With r1=0xFFFFFFFF and r2=1, ADD r4,r1,r2 SHALL give r4=0 and flag[r4]=1 (DATA_W=32).
REQ-035 STORE to address 0x10 with rb=0xDEADBEEF and mem_ready low for 3 cycles SHALL give mem_req/mem_addr/mem_wdata stable for 4 cycles, mem_we=1, and the next FETCH at pc+1.
REQ-036 With ADDR_W=8 and pc=0xFF executing NOP, the next fetch address SHALL be 0x00; opcode 0x3F SHALL pulse illegal for exactly one cycle.
REQ-037 Reset asserted while in MEM with mem_ready=0 SHALL drop mem_req in the same cycle, clear the registers, and start the first fetch at RESET_PC after release.
REQ-038 JZ r5,r6 SHALL jump to r6 when flag[r5]=1 and fall through to pc+1 when flag[r5]=0.
